// File: rtl/reg_file.sv
// reg_file: 2**ADDR_W x DATA_W register file, one write port, two
// registered read ports with write-first bypass.
//
// Ports:
//   clk    : rising-edge clock for all state
//   rst    : asynchronous reset, active low
//   EN     : global enable; when low nothing changes
//   WR     : write request, reg[sel_i1] <= Ip1
//   RD     : read request, Op1/Op2 <= reg[sel_o1]/reg[sel_o2]
//   Ip1    : write data
//   sel_i1 : write address
//   sel_o1 : read address, port 1
//   sel_o2 : read address, port 2
//   Op1    : registered read data, port 1
//   Op2    : registered read data, port 2
//
// Option macro REGFILE_ZERO_REG_EN: register 0 is hardwired to zero.
module reg_file #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              EN,
   input  logic              WR,
   input  logic              RD,
   input  logic [DATA_W-1:0] Ip1,
   input  logic [ADDR_W-1:0] sel_i1,
   input  logic [ADDR_W-1:0] sel_o1,
   input  logic [ADDR_W-1:0] sel_o2,
   output logic [DATA_W-1:0] Op1,
   output logic [DATA_W-1:0] Op2
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic              wr_ok;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;

   // Address 0 is never written when it is the hardwired zero register.
`ifdef REGFILE_ZERO_REG_EN
   assign wr_ok = WR && (sel_i1 != '0);
`else
   assign wr_ok = WR;
`endif

   // Write-first: a read of the address being written sees Ip1.
   always_comb begin
      rd1 = regs[sel_o1];
      if (wr_ok && (sel_o1 == sel_i1)) begin
         rd1 = Ip1;
      end
`ifdef REGFILE_ZERO_REG_EN
      if (sel_o1 == '0) begin
         rd1 = '0;
      end
`endif
   end

   always_comb begin
      rd2 = regs[sel_o2];
      if (wr_ok && (sel_o2 == sel_i1)) begin
         rd2 = Ip1;
      end
`ifdef REGFILE_ZERO_REG_EN
      if (sel_o2 == '0) begin
         rd2 = '0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (EN && wr_ok) begin
         regs[sel_i1] <= Ip1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         Op1 <= '0;
         Op2 <= '0;
      end else if (EN && RD) begin
         Op1 <= rd1;
         Op2 <= rd2;
      end
   end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file.
// Expected values are hand-computed per vector.
module tb_reg_file;

   logic        clk;
   logic        rst;
   logic        EN;
   logic        WR;
   logic        RD;
   logic [31:0] Ip1;
   logic [4:0]  sel_i1;
   logic [4:0]  sel_o1;
   logic [4:0]  sel_o2;
   logic [31:0] Op1;
   logic [31:0] Op2;

   int checks;
   int errors;

   logic [31:0] ones;
   logic [31:0] z_exp;

   reg_file #(
      .DATA_W(32),
      .ADDR_W(5)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .EN    (EN),
      .WR    (WR),
      .RD    (RD),
      .Ip1   (Ip1),
      .sel_i1(sel_i1),
      .sel_o1(sel_o1),
      .sel_o2(sel_o2),
      .Op1   (Op1),
      .Op2   (Op2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic en, input logic wr,
                        input logic rd, input logic [31:0] d,
                        input logic [4:0] wa,
                        input logic [4:0] a1,
                        input logic [4:0] a2);
      EN = en;
      WR = wr;
      RD = rd;
      Ip1 = d;
      sel_i1 = wa;
      sel_o1 = a1;
      sel_o2 = a2;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      ones = 32'hFFFF_FFFF;
`ifdef REGFILE_ZERO_REG_EN
      z_exp = 32'h0;
`else
      z_exp = ones;
`endif
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0);
      #12;
      check("rst_op1", Op1, 32'h0);
      check("rst_op2", Op2, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      drive(1'b1, 1'b1, 1'b1, 32'd14, 5'd2, 5'd4, 5'd6);
      tick();
      check("v1_op1", Op1, 32'h0);
      check("v1_op2", Op2, 32'h0);

      drive(1'b1, 1'b1, 1'b1, 32'd7, 5'd10, 5'd2, 5'd4);
      tick();
      check("v2_op1", Op1, 32'd14);
      check("v2_op2", Op2, 32'h0);

      drive(1'b1, 1'b0, 1'b1, 32'd99, 5'd7, 5'd7, 5'd7);
      tick();
      check("v3_op1", Op1, 32'h0);
      check("v3_op2", Op2, 32'h0);

      drive(1'b1, 1'b0, 1'b1, 32'd99, 5'd0, 5'd0, 5'd10);
      tick();
      check("v4_op1", Op1, 32'h0);
      check("v4_op2", Op2, 32'd7);

      drive(1'b1, 1'b1, 1'b1, 32'h55, 5'd6, 5'd6, 5'd2);
      tick();
      check("byp55_op1", Op1, 32'h55);
      check("byp55_op2", Op2, 32'd14);

      drive(1'b1, 1'b1, 1'b1, 32'h0, 5'd6, 5'd6, 5'd6);
      tick();
      check("byp0_op1", Op1, 32'h0);
      check("byp0_op2", Op2, 32'h0);

      drive(1'b1, 1'b1, 1'b1, ones, 5'd0, 5'd0, 5'd10);
      tick();
      check("r0byp_op1", Op1, z_exp);
      check("r0byp_op2", Op2, 32'd7);

      drive(1'b1, 1'b0, 1'b1, 32'h0, 5'd0, 5'd0, 5'd0);
      tick();
      check("r0rd_op1", Op1, z_exp);
      check("r0rd_op2", Op2, z_exp);

      drive(1'b1, 1'b0, 1'b1, 32'h0, 5'd0, 5'd2, 5'd10);
      tick();
      check("pre_op1", Op1, 32'd14);
      check("pre_op2", Op2, 32'd7);

      // RD=0 write: outputs hold.
      drive(1'b1, 1'b1, 1'b0, 32'hA5, 5'd3, 5'd3, 5'd3);
      tick();
      check("rd0_op1", Op1, 32'd14);
      check("rd0_op2", Op2, 32'd7);

      // EN=0: nothing changes.
      drive(1'b0, 1'b1, 1'b1, 32'h1234, 5'd3, 5'd3, 5'd6);
      tick();
      check("en0_op1", Op1, 32'd14);
      check("en0_op2", Op2, 32'd7);

      drive(1'b1, 1'b0, 1'b1, 32'h1234, 5'd3, 5'd3, 5'd6);
      tick();
      check("rd3_op1", Op1, 32'hA5);
      check("rd6_op2", Op2, 32'h0);

      drive(1'b1, 1'b0, 1'b1, 32'h0, 5'd0, 5'd10, 5'd10);
      tick();
      check("same_op1", Op1, 32'd7);
      check("same_op2", Op2, 32'd7);

      drive(1'b1, 1'b1, 1'b1, 32'hBEEF, 5'd31, 5'd31, 5'd2);
      tick();
      check("a31_op1", Op1, 32'hBEEF);
      check("a31_op2", Op2, 32'd14);

      // Async reset mid-cycle with a write/read pending.
      drive(1'b1, 1'b1, 1'b1, 32'h77, 5'd2, 5'd2, 5'd31);
      #2;
      rst = 1'b0;
      #1;
      check("arst_op1", Op1, 32'h0);
      check("arst_op2", Op2, 32'h0);
      tick();
      check("arst_hold1", Op1, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      drive(1'b1, 1'b0, 1'b1, 32'h0, 5'd0, 5'd2, 5'd31);
      tick();
      check("post_op1", Op1, 32'h0);
      check("post_op2", Op2, 32'h0);

      drive(1'b1, 1'b0, 1'b1, 32'h0, 5'd0, 5'd3, 5'd10);
      tick();
      check("post3_op1", Op1, 32'h0);
      check("post10_op2", Op2, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
